window_peak_tracker: RTL and testbench

- Streaming stage that feeds the team's 16-bit unsigned comparator.
- Accepts 16-bit samples over a valid/ready handshake and groups them into fixed windows of WINDOW samples.
- For each window it reports the maximum, the minimum, and the index of the first maximum.
- Result leaves on a registered valid/ready handshake to the downstream consumer (threshold/alarm logic).

---
 rtl/peak_pkg.sv | 19 +
 rtl/window_peak_tracker_cmp.sv | 16 +
 rtl/window_peak_tracker.sv | 144 ++++++++++++++
 tb/tb_window_peak_tracker.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peak_pkg.sv
// Shared definitions for the window peak tracker: sample width, FSM states,
// and the index-width helper used to size the max-index output.
// Pure declarations; no logic, no latency, no backpressure of its own.
package peak_pkg;

   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Index width for a window of the given size, never narrower than one bit.
   function automatic int idx_width(input int window);
      return (window <= 2) ? 1 : $clog2(window);
   endfunction

endpackage

// File: rtl/window_peak_tracker_cmp.sv
// Unsigned magnitude comparator: flags a > b and a < b.
// Purely combinational, zero latency; no handshake, so no backpressure.
// Ports: a, b (W-bit unsigned operands); gt (a > b); lt (a < b).
module window_peak_tracker_cmp #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         gt,
   output logic         lt
);

   assign gt = (a > b);
   assign lt = (a < b);

endmodule

// File: rtl/window_peak_tracker.sv
// Groups WINDOW unsigned samples and reports max, min and index of the first max.
// Result registered: out_valid rises the cycle after the WINDOW-th accepted sample.
// in_ready drops while a result waits for out_ready (and while clear is high).
// Ports: clk, n_rst (sync, active-low), clear (drop partial window);
//        in_valid/in_ready/in_data sample stream; out_valid/out_ready result
//        handshake carrying out_max, out_min, out_max_idx.
module window_peak_tracker
   import peak_pkg::*;
#(
   parameter  int WINDOW = 8,
   localparam int IDX_W  = idx_width(WINDOW)
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_max,
   output logic [DATA_W-1:0] out_min,
   output logic [IDX_W-1:0]  out_max_idx
);

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] run_max_q, run_max_d;
   logic [DATA_W-1:0] run_min_q, run_min_d;
   logic [IDX_W-1:0]  run_idx_q, run_idx_d;
   logic              out_valid_d;
   logic [DATA_W-1:0] out_max_d, out_min_d;
   logic [IDX_W-1:0]  out_max_idx_d;

   logic              accept;
   logic              last;
   logic              new_max, new_min;
   logic              unused_max_lt, unused_min_gt;

   // Strictly greater only: a tie keeps the earlier index.
   window_peak_tracker_cmp #(.W(DATA_W)) u_cmp_max (
      .a  (in_data),
      .b  (run_max_q),
      .gt (new_max),
      .lt (unused_max_lt)
   );

   window_peak_tracker_cmp #(.W(DATA_W)) u_cmp_min (
      .a  (in_data),
      .b  (run_min_q),
      .gt (unused_min_gt),
      .lt (new_min)
   );

   assign in_ready = (state_q != DONE) && !clear;
   assign accept   = in_valid && in_ready;
   assign last     = (count_q == IDX_W'(WINDOW - 1));

   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      run_max_d     = run_max_q;
      run_min_d     = run_min_q;
      run_idx_d     = run_idx_q;
      out_valid_d   = out_valid;
      out_max_d     = out_max;
      out_min_d     = out_min;
      out_max_idx_d = out_max_idx;

      case (state_q)
         IDLE: begin
            if (accept) begin
               run_max_d = in_data;
               run_min_d = in_data;
               run_idx_d = '0;
               count_d   = IDX_W'(1);
               state_d   = ACCUM;
            end
         end
         ACCUM: begin
            if (accept) begin
               if (new_max) begin
                  run_max_d = in_data;
                  run_idx_d = count_q;
               end
               if (new_min) begin
                  run_min_d = in_data;
               end
               count_d = count_q + IDX_W'(1);
               if (last) begin
                  // Publish the values that include this final sample.
                  out_max_d     = run_max_d;
                  out_min_d     = run_min_d;
                  out_max_idx_d = run_idx_d;
                  out_valid_d   = 1'b1;
                  state_d       = DONE;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               count_d     = '0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Drops the partial window or pending result; published data is kept.
      if (clear) begin
         state_d     = IDLE;
         count_d     = '0;
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q     <= IDLE;
         count_q     <= '0;
         run_max_q   <= '0;
         run_min_q   <= '0;
         run_idx_q   <= '0;
         out_valid   <= 1'b0;
         out_max     <= '0;
         out_min     <= '0;
         out_max_idx <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         run_max_q   <= run_max_d;
         run_min_q   <= run_min_d;
         run_idx_q   <= run_idx_d;
         out_valid   <= out_valid_d;
         out_max     <= out_max_d;
         out_min     <= out_min_d;
         out_max_idx <= out_max_idx_d;
      end
   end

endmodule

// File: tb/tb_window_peak_tracker.sv
// Self-checking bench for window_peak_tracker with WINDOW=4.
// Directed vector table, multi-cycle corner sequences, then randomized windows.
// Outputs are sampled 1 time unit after each rising edge.
module tb_window_peak_tracker;

   localparam int WINDOW = 4;
   localparam int IDX_W  = 2;

   logic              clk = 1'b0;
   logic              n_rst;
   logic              clear;
   logic              in_valid;
   logic              in_ready;
   logic [15:0]       in_data;
   logic              out_valid;
   logic              out_ready;
   logic [15:0]       out_max;
   logic [15:0]       out_min;
   logic [IDX_W-1:0]  out_max_idx;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      string           name;
      logic [3:0][15:0] s;
      logic [15:0]     mx;
      logic [15:0]     mn;
      int              idx;
   } vec_t;

   vec_t vecs[5];

   always #5 clk = ~clk;

   window_peak_tracker #(.WINDOW(WINDOW)) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .clear       (clear),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_max     (out_max),
      .out_min     (out_min),
      .out_max_idx (out_max_idx)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_vec(input int i, input string name,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d,
                          input logic [15:0] mx, input logic [15:0] mn, input int idx);
      vecs[i].name = name;
      vecs[i].s[0] = a;
      vecs[i].s[1] = b;
      vecs[i].s[2] = c;
      vecs[i].s[3] = d;
      vecs[i].mx   = mx;
      vecs[i].mn   = mn;
      vecs[i].idx  = idx;
   endtask

   // Four samples on consecutive cycles; returns one time unit after the last edge.
   task automatic send_b2b(input logic [3:0][15:0] w);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = w[i];
         step();
      end
      in_valid = 1'b0;
   endtask

   task automatic check_result(input string name, input logic [15:0] mx,
                               input logic [15:0] mn, input int idx);
      check({name, "_valid"}, 32'(out_valid), 32'd1);
      check({name, "_max"}, 32'(out_max), 32'(mx));
      check({name, "_min"}, 32'(out_min), 32'(mn));
      check({name, "_idx"}, 32'(out_max_idx), 32'(idx));
   endtask

   // Reference: max and min over the window, then the first position holding the max.
   task automatic ref_window(input logic [15:0] w[4], output logic [15:0] mx,
                             output logic [15:0] mn, output int idx);
      mx = w[0];
      mn = w[0];
      foreach (w[j]) begin
         if (int'(w[j]) > int'(mx)) mx = w[j];
         if (int'(w[j]) < int'(mn)) mn = w[j];
      end
      idx = -1;
      foreach (w[j]) begin
         if (idx < 0 && w[j] == mx) idx = j;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0][15:0] w;
      logic [15:0]      hold_max;
      int               seen;
      logic [15:0]      got_max, got_min;
      logic [IDX_W-1:0] got_idx;

      n_rst     = 1'b0;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 16'h0;
      out_ready = 1'b0;

      // Reset
      step();
      step();
      n_rst = 1'b1;
      #1;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_max", 32'(out_max), 32'd0);
      check("rst_min", 32'(out_min), 32'd0);
      check("rst_idx", 32'(out_max_idx), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Directed vectors
      set_vec(0, "basic",   16'd5, 16'd9, 16'd2, 16'd7, 16'd9, 16'd2, 1);
      set_vec(1, "ties",    16'd3, 16'd8, 16'd8, 16'd1, 16'd8, 16'd1, 1);
      set_vec(2, "extreme", 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 0);
      set_vec(3, "allsame", 16'd4, 16'd4, 16'd4, 16'd4, 16'd4, 16'd4, 0);
      set_vec(4, "rising",  16'd1, 16'd2, 16'd3, 16'd4, 16'd4, 16'd1, 3);

      out_ready = 1'b1;
      for (int v = 0; v < 5; v++) begin
         send_b2b(vecs[v].s);
         check_result(vecs[v].name, vecs[v].mx, vecs[v].mn, vecs[v].idx);
         step();
         check({vecs[v].name, "_drop"}, 32'(out_valid), 32'd0);
      end

      // Backpressure: result held, input blocked, then sample 10 opens the next window
      out_ready = 1'b0;
      w = {16'd4, 16'd3, 16'd2, 16'd1};
      send_b2b(w);
      check_result("bp", 16'd4, 16'd1, 3);
      in_valid = 1'b1;
      in_data  = 16'd10;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_hold_max", 32'(out_max), 32'd4);
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         step();
      end
      out_ready = 1'b1;
      step();
      check("bp_release_valid", 32'(out_valid), 32'd0);
      check("bp_release_ready", 32'(in_ready), 32'd1);
      step();                         // 10 accepted here
      in_data = 16'd3;
      step();
      in_data = 16'd5;
      step();
      in_data = 16'd2;
      step();
      in_valid = 1'b0;
      check_result("bp_next", 16'd10, 16'd2, 0);
      step();

      // Gapped input 4, -, 6, -, -, 1, 5
      begin
         logic        gv[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
         logic [15:0] gd[7] = '{16'd4, 16'd0, 16'd6, 16'd0, 16'd0, 16'd1, 16'd5};
         seen = 0;
         got_max = '0;
         got_min = '0;
         got_idx = '0;
         for (int i = 0; i < 10; i++) begin
            in_valid = (i < 7) ? gv[i] : 1'b0;
            in_data  = (i < 7) ? gd[i] : 16'd0;
            step();
            if (out_valid) begin
               seen++;
               got_max = out_max;
               got_min = out_min;
               got_idx = out_max_idx;
            end
         end
         in_valid = 1'b0;
         check("gap_once", 32'(seen), 32'd1);
         check("gap_max", 32'(got_max), 32'd6);
         check("gap_min", 32'(got_min), 32'd1);
         check("gap_idx", 32'(got_idx), 32'd1);
      end

      // Clear mid-window keeps the last published result
      in_valid = 1'b1;
      in_data  = 16'd7;
      step();
      in_data = 16'd9;
      step();
      in_valid = 1'b0;
      clear    = 1'b1;
      #1;
      check("clr_in_ready", 32'(in_ready), 32'd0);
      step();
      clear = 1'b0;
      check("clr_valid", 32'(out_valid), 32'd0);
      check("clr_keep_max", 32'(out_max), 32'd6);
      check("clr_keep_min", 32'(out_min), 32'd1);
      check("clr_keep_idx", 32'(out_max_idx), 32'd1);
      w = {16'd4, 16'd3, 16'd2, 16'd1};
      send_b2b(w);
      check_result("clr_new", 16'd4, 16'd1, 3);
      step();

      // Reset mid-window wipes everything
      in_valid = 1'b1;
      in_data  = 16'd7;
      step();
      in_data = 16'd9;
      step();
      in_valid = 1'b0;
      n_rst    = 1'b0;
      step();
      n_rst = 1'b1;
      check("mrst_valid", 32'(out_valid), 32'd0);
      check("mrst_max", 32'(out_max), 32'd0);
      check("mrst_min", 32'(out_min), 32'd0);
      check("mrst_idx", 32'(out_max_idx), 32'd0);
      send_b2b(w);
      check_result("mrst_new", 16'd4, 16'd1, 3);
      step();

      // Randomized windows with gaps and backpressure
      out_ready = 1'b0;
      for (int n = 0; n < 300; n++) begin
         logic [15:0] rw[4];
         logic [15:0] emx, emn;
         int          eidx;
         int          waited;
         for (int i = 0; i < 4; i++) begin
            rw[i] = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 7))
                                                : 16'($urandom);
         end
         ref_window(rw, emx, emn, eidx);
         for (int i = 0; i < 4; i++) begin
            int gaps = $urandom_range(0, 2);
            in_valid = 1'b0;
            for (int g = 0; g < gaps; g++) step();
            in_valid = 1'b1;
            in_data  = rw[i];
            step();
         end
         in_valid = 1'b0;
         waited = 0;
         while (!out_valid && waited < 8) begin
            step();
            waited++;
         end
         check_result("rand", emx, emn, eidx);
         hold_max = out_max;
         for (int h = int'($urandom_range(0, 3)); h > 0; h--) begin
            step();
            check("rand_hold", 32'(out_max), 32'(hold_max));
         end
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
         check("rand_drop", 32'(out_valid), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
